branch_redirect_fetch: RTL

PC sequencer at the consuming end of the branch-decision interface. It takes the execute stage's branch resolution (valid/taken/target) and drives the fetch side. It owns the PC register, issues instruction-memory requests over a req/ready handshake, and redirects the PC on a taken branch. After a redirect it asserts a multi-cycle flush to the front-end pipeline, and it traps on misaligned branch targets.

---
 rtl/branch_redirect_fetch.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/branch_redirect_fetch.sv
// ---------------------------------------------------------------------------
// branch_redirect_fetch
//
// PC sequencer for the fetch front end. Owns the PC, issues instruction
// memory requests over a req/ready handshake, redirects on taken branches
// from execute, holds a multi-cycle flush after each redirect and traps
// (sticky) on misaligned branch targets.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   br_valid        branch resolution present this cycle
//   br_taken        resolved outcome, qualified by br_valid
//   br_target       branch target, qualified by br_valid && br_taken
//   stall           back-pressure; blocks new requests only
//   imem_req        fetch request (transfer = imem_req && imem_ready)
//   imem_addr       fetch address, held while a request waits for ready
//   imem_ready      memory accepts the request
//   fetch_valid     registered one-cycle pulse per unsquashed transfer
//   fetch_pc        address of the transfer reported by fetch_valid
//   flush           squash younger front-end instructions
//   misalign_fault  sticky trap on a taken misaligned branch
//   redirect_count  taken aligned redirects, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module branch_redirect_fetch #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    output logic            flush,
    output logic            misalign_fault,
    output logic [15:0]     redirect_count
);

    localparam int              CNT_W      = 4;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_FLUSH,
        ST_FAULT
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t          state,         state_d;
    logic [XLEN-1:0] pc,            pc_d;
    logic [CNT_W-1:0] flush_cnt,    flush_cnt_d;
    logic            pend_redirect, pend_redirect_d;
    logic [XLEN-1:0] pend_target,   pend_target_d;
    logic            pend_fault,    pend_fault_d;
    logic            fault_q,       fault_d;
    logic [15:0]     count_q,       count_d;
    logic            vld_p1,        vld_d;
    logic [XLEN-1:0] fetch_pc_p1,   fetch_pc_d;

    logic br_ok;
    logic br_bad;
    logic xfer;

    assign br_ok  = br_valid && br_taken && (br_target[1:0] == 2'b00);
    assign br_bad = br_valid && br_taken && (br_target[1:0] != 2'b00);

    always_comb begin
        state_d         = state;
        pc_d            = pc;
        flush_cnt_d     = flush_cnt;
        pend_redirect_d = pend_redirect;
        pend_target_d   = pend_target;
        pend_fault_d    = pend_fault;
        fault_d         = fault_q;
        count_d         = count_q;
        vld_d           = 1'b0;
        fetch_pc_d      = fetch_pc_p1;
        imem_req        = 1'b0;
        imem_addr       = pc;
        xfer            = 1'b0;

        unique case (state)
            ST_RUN: begin
                imem_req = !stall;
                xfer     = imem_req && imem_ready;
                // A branch wins over a same-cycle transfer, which is squashed.
                if (br_bad) begin
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                end else if (br_ok) begin
                    pc_d        = br_target;
                    flush_cnt_d = FLUSH_LOAD;
                    count_d     = sat_inc16(count_q);
                    state_d     = ST_FLUSH;
                end else if (xfer) begin
                    pc_d       = pc + XLEN'(4);
                    vld_d      = 1'b1;
                    fetch_pc_d = pc;
                end else if (imem_req) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // Request must stay up until accepted, regardless of stall.
                imem_req = 1'b1;
                if (imem_ready) begin
                    pend_redirect_d = 1'b0;
                    pend_fault_d    = 1'b0;
                    if (pend_fault || br_bad) begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else if (br_ok) begin
                        pc_d        = br_target;
                        flush_cnt_d = FLUSH_LOAD;
                        count_d     = sat_inc16(count_q);
                        state_d     = ST_FLUSH;
                    end else if (pend_redirect) begin
                        pc_d        = pend_target;
                        flush_cnt_d = FLUSH_LOAD;
                        state_d     = ST_FLUSH;
                    end else begin
                        pc_d       = pc + XLEN'(4);
                        vld_d      = 1'b1;
                        fetch_pc_d = pc;
                        state_d    = ST_RUN;
                    end
                end else if (br_bad) begin
                    // Fault is visible now; the outstanding transfer still
                    // has to complete before the sequencer parks.
                    fault_d      = 1'b1;
                    pend_fault_d = 1'b1;
                end else if (br_ok && !pend_fault) begin
                    pend_redirect_d = 1'b1;
                    pend_target_d   = br_target;
                    count_d         = sat_inc16(count_q);
                end
            end

            ST_FLUSH: begin
                if (br_bad) begin
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                end else if (br_ok) begin
                    pc_d        = br_target;
                    flush_cnt_d = FLUSH_LOAD;
                    count_d     = sat_inc16(count_q);
                end else if (flush_cnt == CNT_W'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt - CNT_W'(1);
                end
            end

            ST_FAULT: begin
                state_d = ST_FAULT;
            end

            default: begin
                state_d = ST_FAULT;
            end
        endcase

        if (rst) begin
            imem_req = 1'b0;
        end
    end

    // ---- stage boundary: sequencer state -> registered fetch report ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            pc            <= RESET_PC;
            flush_cnt     <= '0;
            pend_redirect <= 1'b0;
            pend_fault    <= 1'b0;
            fault_q       <= 1'b0;
            count_q       <= '0;
            vld_p1        <= 1'b0;
            fetch_pc_p1   <= '0;
        end else begin
            state         <= state_d;
            pc            <= pc_d;
            flush_cnt     <= flush_cnt_d;
            pend_redirect <= pend_redirect_d;
            pend_fault    <= pend_fault_d;
            fault_q       <= fault_d;
            count_q       <= count_d;
            vld_p1        <= vld_d;
            fetch_pc_p1   <= fetch_pc_d;
        end
    end

    // Pending target is only read when pend_redirect is set, so it needs no reset.
    always_ff @(posedge clk) begin
        pend_target <= pend_target_d;
    end

    assign fetch_valid    = vld_p1;
    assign fetch_pc       = fetch_pc_p1;
    assign flush          = (state == ST_FLUSH);
    assign misalign_fault = fault_q;
    assign redirect_count = count_q;

endmodule
